// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-side master for the async FIFO, living entirely in the rd_clk domain.
// Issues reads against the FIFO flags, tracks each read through a tag pipeline
// until its ack/err response, commits good data into a small circular buffer
// and presents that buffer as a valid/ready stream.
//
// Ports
//   rd_clk            clock
//   clear             synchronous active-high reset
//   enable            permit new reads
//   fifo_empty        FIFO empty flag
//   fifo_almost_empty FIFO holds one entry
//   fifo_rd_en        read request (combinational)
//   fifo_dout         FIFO read data, valid DATA_LAT cycles after issue
//   fifo_rd_ack       read success, ACK_LAT cycles after issue
//   fifo_rd_err       read failure, ACK_LAT cycles after issue
//   m_valid/m_ready   output stream handshake
//   m_data            output stream data (head of buffer, registered)
//   err_cnt           failed or lost reads, saturating at 255
//   proto_err         sticky protocol-violation flag
//   inflight          reads issued and not yet resolved
module fifo_rd_drain #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 4,
  parameter int DATA_LAT  = 1,
  parameter int ACK_LAT   = 2
) (
  input  logic             rd_clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_rd_ack,
  input  logic             fifo_rd_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [7:0]       err_cnt,
  output logic             proto_err,
  output logic [2:0]       inflight
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(ACK_LAT + 1);
  localparam int DL = ACK_LAT - DATA_LAT;

  // tag_q[0] is stage 1 (set by the issuing edge); tag_q[ACK_LAT-1] is the
  // stage whose response is on fifo_rd_ack/fifo_rd_err this cycle.
  logic [ACK_LAT-1:0]                tag_q;
  logic [2:0]                        inflight_q, inflight_d;
  logic [7:0]                        err_cnt_q;
  logic                              proto_q;
  logic [IW-1:0]                     ign_q;
  logic [BUF_DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
  logic [AW-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                     count_q, count_d;
  logic [WIDTH-1:0]                  m_data_q;
  logic [WIDTH-1:0]                  res_data;
  logic                              tag_out, push, pop, err_inc, proto_set;

  assign tag_out = tag_q[ACK_LAT-1];

  // Carry the captured read data from the DATA_LAT stage to the resolving
  // stage so it lines up with its tag.
  generate
    if (DL == 0) begin : g_nodp
      assign res_data = fifo_dout;
    end else begin : g_dp
      localparam int DPW = DL * WIDTH;
      logic [DL-1:0][WIDTH-1:0] dpipe_q;
      always_ff @(posedge rd_clk) begin
        if (clear) dpipe_q <= '0;
        else       dpipe_q <= DPW'({dpipe_q, fifo_dout});
      end
      assign res_data = dpipe_q[DL-1];
    end
  endgenerate

  // Credit check keeps buffered + outstanding within the buffer, so a push
  // can never find the buffer full. The almost-empty term stops a second
  // read against the last entry while the flags still lag the first read.
  always_comb begin
    fifo_rd_en = enable && !fifo_empty &&
                 ((int'(inflight_q) + int'(count_q)) < BUF_DEPTH) &&
                 !(fifo_almost_empty && (inflight_q != '0));
  end

  // Response resolution. During the post-clear window no tags are live, so
  // only the unsolicited-response check needs gating.
  always_comb begin
    push      = 1'b0;
    err_inc   = 1'b0;
    proto_set = 1'b0;
    if (tag_out) begin
      if (fifo_rd_ack && !fifo_rd_err) begin
        push = 1'b1;
      end else begin
        err_inc = 1'b1;
        // both high or both low is a protocol violation
        if (fifo_rd_ack == fifo_rd_err) proto_set = 1'b1;
      end
    end else if ((fifo_rd_ack || fifo_rd_err) && (ign_q == '0)) begin
      proto_set = 1'b1;
    end
  end

  assign pop = (count_q != '0) && m_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = res_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    case ({fifo_rd_en, tag_out})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (clear) begin
      tag_q      <= '0;
      inflight_q <= '0;
      err_cnt_q  <= '0;
      proto_q    <= 1'b0;
      ign_q      <= IW'(ACK_LAT);
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_data_q   <= '0;
    end else begin
      tag_q      <= ACK_LAT'({tag_q, fifo_rd_en});
      inflight_q <= inflight_d;
      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (proto_set) proto_q <= 1'b1;
      if (ign_q != '0) ign_q <= ign_q - IW'(1);
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      // head of the next-state buffer, so a push into an empty buffer is
      // visible together with m_valid
      m_data_q   <= mem_d[rd_ptr_d];
    end
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = m_data_q;
  assign err_cnt   = err_cnt_q;
  assign proto_err = proto_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;
  localparam int W = 8, D = 4, DLAT = 1, ALAT = 2;

  logic         rd_clk = 1'b0;
  logic         clear, enable, fifo_empty, fifo_almost_empty, fifo_rd_en;
  logic [W-1:0] fifo_dout, m_data;
  logic         fifo_rd_ack, fifo_rd_err, m_valid, m_ready, proto_err;
  logic [7:0]   err_cnt;
  logic [2:0]   inflight;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.WIDTH(W), .BUF_DEPTH(D), .DATA_LAT(DLAT), .ACK_LAT(ALAT)) dut (
    .rd_clk(rd_clk), .clear(clear), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_cnt(err_cnt), .proto_err(proto_err), .inflight(inflight)
  );

  int checks = 0, errors = 0, cyc = 0;

  // FIFO environment: contents plus a small schedule of future responses
  logic [7:0] fq[$];
  logic [7:0] r_dat[8];
  bit         r_dv[8], r_ack[8], r_err[8];
  int         reads = 0, underflows = 0, err_idx = -1;
  bit         err_all = 0, rand_resp = 0, inj_ack = 0;

  // Reference model: outstanding reads with due cycle, and the output queue
  typedef struct { int due; logic [7:0] d; } rd_t;
  rd_t        mout[$];
  logic [7:0] mq[$];
  int         merr = 0, ign_until = -100;
  bit         mproto = 0;

  // observations
  int         rd_pulses = 0, first_rd = -1, first_v = -1;
  logic [7:0] got[$];
  int         got_cyc[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_flags(int sz);
    fifo_empty        = (sz == 0);
    fifo_almost_empty = (sz == 1);
  endtask

  task automatic preload_seq(logic [7:0] base, int cnt);
    for (int i = 0; i < cnt; i++) fq.push_back(8'(base + i));
    set_flags(fq.size());
  endtask

  task automatic preload_rand(int cnt);
    for (int i = 0; i < cnt; i++) fq.push_back(8'($urandom));
    set_flags(fq.size());
  endtask

  task automatic clr_obs();
    got.delete(); got_cyc.delete(); first_rd = -1; first_v = -1;
  endtask

  // One clock cycle: check at the falling edge, then advance the model and
  // the FIFO environment just after the rising edge.
  task automatic step();
    bit rd, ack, err, rerr, rack;
    logic [7:0] w;
    int sz, n, k;
    rd_t r;
    @(negedge rd_clk);
    chk("rd_en", fifo_rd_en, enable && !fifo_empty && (mout.size() + mq.size() < D) &&
                             !(fifo_almost_empty && mout.size() != 0));
    chk("m_valid", m_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", m_data, mq[0]);
    chk("inflight", inflight, mout.size());
    chk("err_cnt", err_cnt, merr);
    chk("proto_err", proto_err, mproto);
    rd = fifo_rd_en; ack = fifo_rd_ack; err = fifo_rd_err;
    if (rd) begin rd_pulses++; if (first_rd < 0) first_rd = cyc; end
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready) begin got.push_back(m_data); got_cyc.push_back(cyc); end
    @(posedge rd_clk); #1;
    if (clear) begin
      mq.delete(); mout.delete(); merr = 0; mproto = 0; ign_until = cyc + ALAT;
    end else begin
      if (mq.size() != 0 && m_ready) void'(mq.pop_front());
      if (mout.size() != 0 && mout[0].due == cyc) begin
        r = mout.pop_front();
        if (ack && !err) mq.push_back(r.d);
        else begin
          if (merr < 255) merr++;
          if (ack == err) mproto = 1;
        end
      end else if ((ack || err) && cyc > ign_until) begin
        mproto = 1;
      end
    end
    sz = fq.size();
    if (rd) begin
      if (sz == 0) begin
        underflows++; w = 8'($urandom); rerr = 1; rack = 0;
      end else begin
        w = fq.pop_front();
        rerr = err_all || (reads == err_idx);
        rack = !rerr;
        if (rand_resp) begin
          k = $urandom_range(0, 9);
          if (k == 7) begin rack = 0; rerr = 1; end
          if (k == 8) begin rack = 0; rerr = 0; end
          if (k == 9) begin rack = 1; rerr = 1; end
        end
      end
      reads++;
      r_dat[(cyc + DLAT) % 8] = w; r_dv[(cyc + DLAT) % 8] = 1;
      r_ack[(cyc + ALAT) % 8] = rack; r_err[(cyc + ALAT) % 8] = rerr;
      if (!clear) mout.push_back('{cyc + ALAT, w});
    end
    n = (cyc + 1) % 8;
    fifo_dout   = r_dv[n] ? r_dat[n] : 8'($urandom);
    fifo_rd_ack = r_ack[n] | inj_ack;
    fifo_rd_err = r_err[n];
    r_dv[n] = 0; r_ack[n] = 0; r_err[n] = 0; inj_ack = 0;
    set_flags(sz);
    cyc++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0, u0, e0;
    bit reached;
    clear = 1; enable = 0; m_ready = 0;
    fifo_dout = '0; fifo_rd_ack = 0; fifo_rd_err = 0; set_flags(0);
    @(posedge rd_clk); #1;
    steps(2);
    clear = 0;
    @(negedge rd_clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    steps(3);

    // streaming at full rate
    clr_obs(); preload_seq(8'h11, 8); enable = 1; m_ready = 1;
    steps(16);
    chk("t1_latency", first_v - first_rd, ALAT + 1);
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("t1_data", got[i], 8'(8'h11 + i));
    if (got.size() == 8) chk("t1_rate", got_cyc[7] - got_cyc[0], 7);
    chk("t1_err_cnt", err_cnt, 0);

    // back-pressure: only BUF_DEPTH reads go out
    clr_obs(); m_ready = 0; p0 = rd_pulses; preload_seq(8'h11, 8);
    steps(12);
    chk("t2_reads", rd_pulses - p0, D);
    chk("t2_inflight", inflight, 0);
    chk("t2_valid", m_valid, 1);
    chk("t2_head", m_data, 8'h11);
    m_ready = 1;
    steps(16);
    chk("t2_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("t2_data", got[i], 8'(8'h11 + i));

    // single entry with almost_empty: exactly one read
    clr_obs(); p0 = rd_pulses; u0 = underflows; e0 = err_cnt;
    preload_seq(8'h5A, 1);
    steps(8);
    chk("t3_reads", rd_pulses - p0, 1);
    chk("t3_underflow", underflows - u0, 0);
    chk("t3_err_cnt", err_cnt, e0);
    chk("t3_data", got.size() == 1 ? got[0] : 32'hFFFF, 8'h5A);

    // error on the middle of three reads
    clr_obs(); e0 = err_cnt; err_idx = reads + 1;
    preload_seq(8'hA1, 3);
    steps(10);
    err_idx = -1;
    chk("t4_count", got.size(), 2);
    if (got.size() == 2) begin chk("t4_d0", got[0], 8'hA1); chk("t4_d1", got[1], 8'hA3); end
    chk("t4_err_cnt", err_cnt, e0 + 1);
    chk("t4_proto", proto_err, 0);

    // randomized traffic, including lost and double responses
    rand_resp = 1;
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if (fq.size() < 3 && $urandom_range(0, 3) == 0) preload_rand($urandom_range(1, 4));
      step();
    end
    rand_resp = 0; enable = 0; m_ready = 1;
    steps(10);
    fq.delete(); set_flags(0);
    clear = 1; step(); clear = 0;
    steps(4);
    chk("t5_pre_proto", proto_err, 0);

    // unsolicited ack with two words buffered
    m_ready = 0; enable = 1; preload_seq(8'hC1, 2);
    steps(8);
    enable = 0;
    inj_ack = 1;
    steps(2);
    chk("t5_proto", proto_err, 1);
    chk("t5_valid", m_valid, 1);
    steps(5);
    chk("t5_sticky", proto_err, 1);
    clr_obs(); m_ready = 1;
    steps(6);
    chk("t5_count", got.size(), 2);
    if (got.size() == 2) begin chk("t5_d0", got[0], 8'hC1); chk("t5_d1", got[1], 8'hC2); end

    // clear with reads in flight and words buffered
    m_ready = 0; enable = 1; err_idx = reads; preload_seq(8'h31, 8);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      reached = (mq.size() == 2 && mout.size() == 2);
    end
    chk("t6_reach", reached, 1);
    chk("t6_pre_err", err_cnt, 1);
    clear = 1; enable = 0; step(); clear = 0;
    chk("t6_valid", m_valid, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_m_data", m_data, 0);
    steps(5);
    chk("t6_late_proto", proto_err, 0);
    chk("t6_late_valid", m_valid, 0);
    err_idx = -1; fq.delete(); set_flags(0);
    steps(2);

    // saturation of the error counter
    err_all = 1; enable = 1; m_ready = 1; preload_rand(260);
    steps(290);
    chk("t7_sat", err_cnt, 255);
    steps(10);
    chk("t7_hold", err_cnt, 255);
    chk("t7_proto", proto_err, 0);
    err_all = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
